// File: rtl/p2m_echo_indication_marshal.sv
// Packs say2/say/setLeds method calls into 128-bit portal messages and queues
// them toward the downstream pipe through a small FIFO with registered outputs.
module p2m_echo_indication_marshal #(
    parameter int          DEPTH      = 2,
    parameter logic [15:0] ID_SAY2    = 16'd0,
    parameter logic [15:0] ID_SAY     = 16'd1,
    parameter logic [15:0] ID_SETLEDS = 16'd2
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic           method_say2__ENA,
    input  logic [15:0]    method_say2_a,
    input  logic [15:0]    method_say2_b,
    output logic           method_say2__RDY,
    input  logic           method_say__ENA,
    input  logic [31:0]    method_say_v,
    output logic           method_say__RDY,
    input  logic           method_setLeds__ENA,
    input  logic [7:0]     method_setLeds_v,
    output logic           method_setLeds__RDY,
    output logic           pipe_enq__ENA,
    output logic [127:0]   pipe_enq_v,
    input  logic           pipe_enq__RDY
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = CW'(0);

    // Every message is two words long: header word plus one payload word.
    function automatic logic [127:0] pack_msg(input logic [15:0] id, input logic [31:0] payload);
        pack_msg = {64'd0, payload, id, 16'd2};
    endfunction

    logic [127:0]  mem_q [DEPTH];
    logic [127:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          ena_q, ena_d;
    logic [127:0]  head_q, head_d;
    logic          enq_s;
    logic          deq_s;
    logic [127:0]  msg_s;

    assign method_say2__RDY    = !full_q;
    assign method_say__RDY     = !full_q && !method_say2__ENA;
    assign method_setLeds__RDY = !full_q && !method_say2__ENA && !method_say__ENA;
    assign pipe_enq__ENA       = ena_q;
    assign pipe_enq_v          = head_q;

    // Call arbitration, FIFO bookkeeping and next value of the registered head.
    always_comb begin
        enq_s = 1'b0;
        msg_s = 128'd0;
        if (!full_q) begin
            if (method_say2__ENA) begin
                enq_s = 1'b1;
                msg_s = pack_msg(ID_SAY2, {method_say2_b, method_say2_a});
            end else if (method_say__ENA) begin
                enq_s = 1'b1;
                msg_s = pack_msg(ID_SAY, method_say_v);
            end else if (method_setLeds__ENA) begin
                enq_s = 1'b1;
                msg_s = pack_msg(ID_SETLEDS, {24'd0, method_setLeds_v});
            end else begin
                enq_s = 1'b0;
            end
        end else begin
            enq_s = 1'b0;
        end

        deq_s = ena_q && pipe_enq__RDY;

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (enq_s) begin
            mem_d[wr_ptr_q] = msg_s;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end

        if (deq_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d = (count_d == CNT_FULL);
        ena_d  = (count_d != CNT_EMPTY);

        // A write landing on the new head slot must be forwarded into the head register.
        if (enq_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = msg_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // State registers; reset discards all queued messages.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 128'd0;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            full_q   <= 1'b0;
            ena_q    <= 1'b0;
            head_q   <= 128'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ena_q    <= ena_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: doc/p2m_echo_indication_marshal.md
Name: p2m_echo_indication_marshal

Overview:
- Method-to-pipe marshaller: the transmit-side counterpart of the portal request demux.
- Accepts atomic method calls `say2(a,b)`, `say(v)` and `setLeds(v)` from the user side.
- Packs each call into one 128-bit portal message.
- Buffers messages in a small FIFO and presents them to a downstream pipe via an ENA/RDY handshake. Sits between user logic and the portal transport toward software.

Parameters:
- DEPTH, 2: FIFO entries; power of two, >= 2.
- ID_SAY2, 0: method id for say2.
- ID_SAY, 1: method id for say.
- ID_SETLEDS, 2: method id for setLeds.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- method$say2__ENA  input  1  say2 call strobe
- method$say2$a  input  16  say2 arg a
- method$say2$b  input  16  say2 arg b
- method$say2__RDY  output  1  say2 may be called
- method$say__ENA  input  1  say call strobe
- method$say$v  input  32  say arg
- method$say__RDY  output  1  say may be called
- method$setLeds__ENA  input  1  setLeds call strobe
- method$setLeds$v  input  8  setLeds arg
- method$setLeds__RDY  output  1  setLeds may be called
- pipe$enq__ENA  output  1  message valid to downstream
- pipe$enq$v  output  128  message
- pipe$enq__RDY  input  1  downstream can take message

Behaviour:
- Interface: one clock CLK; reset nRST is asynchronous, active-low.
- Reset: FIFO empty, read/write pointers and count = 0, pipe$enq__ENA = 0, pipe$enq$v = 0. All method RDYs are 1 once nRST deasserts.
- Message format:
  - [15:0] = length in 32-bit words including header; always 16'd2.
  - [31:16] = method id.
  - say2: [47:32] = a, [63:48] = b.
  - say: [63:32] = v.
  - setLeds: [39:32] = v.
  - All unused bits, up to [127], are 0.
- Readiness and priority:
  - full = (count == DEPTH), registered; there is no bypass of a full FIFO.
  - method$say2__RDY = !full.
  - method$say__RDY = !full & !method$say2__ENA.
  - method$setLeds__RDY = !full & !method$say2__ENA & !method$say__ENA.
  - Callers assert ENA only when the corresponding RDY is high. At most one call is accepted per cycle, and priority is say2 > say > setLeds.
- Enqueue: an accepted call writes the formatted message at the write pointer on the clock edge. The pointer wraps modulo DEPTH.
- Output:
  - pipe$enq__ENA = (count != 0); pipe$enq$v = entry at the read pointer.
  - Latency from accepted call to pipe$enq__ENA is exactly 1 cycle when the FIFO was empty.
  - No combinational path from method inputs to pipe outputs.
- Dequeue: when pipe$enq__ENA & pipe$enq__RDY, the read pointer advances with wrap.
  - pipe$enq__ENA and pipe$enq$v hold stable while pipe$enq__RDY = 0.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
  - When full, a same-cycle dequeue does not let a call in that cycle; RDY rises the next cycle.
- Ordering: messages leave strictly in acceptance order; none are dropped or duplicated.
- Reset mid-operation: all queued messages are discarded immediately (asynchronous), and outputs go to their reset values.

Test Plan:
1. Single say: after reset, `say(v=32'hDEADBEEF)` -> next cycle pipe$enq__ENA=1, pipe$enq$v = {64'h0, 32'hDEADBEEF, 16'd1, 16'd2}; with pipe$enq__RDY=1 held, ENA drops the following cycle.
2. Format and priority: same cycle say2(a=16'h1234, b=16'h5678), say(7), setLeds(8'hA5) ENA with RDYs obeyed -> only say2 is accepted, and pipe$enq$v[63:32] = 32'h56781234, [31:16] = 0. Then setLeds alone -> [39:32] = 8'hA5, [31:16] = 2, [127:40] = 0.
3. Backpressure and full: pipe$enq__RDY=0, issue say(1), say(2) -> all RDYs go 0 after the second. Outputs hold message 1; raise RDY -> message 1 then message 2 on consecutive cycles, and RDYs return to 1 one cycle after the first dequeue.
4. Streaming: pipe$enq__RDY=1, issue say(n) for n=0..9 every cycle -> RDY never drops, outputs appear n=0..9 in order one cycle delayed, and pointer wrap is exercised.
5. Full with simultaneous dequeue: FIFO full, RDY=1 and say(3) pending -> say RDY stays 0 that cycle, is 1 the next, and the message is accepted then.
6. Reset mid-operation: 2 messages queued, pulse nRST low asynchronously mid-cycle -> pipe$enq__ENA=0 immediately; after release the FIFO is empty and RDYs are 1.
